// File: rtl/obj_pkg.sv
// Shared object codes, transparency key and FSM state type for the object select encoder.
package obj_pkg;

  localparam logic [7:0] BACKGROUND = 8'd0;
  localparam logic [7:0] WATERFALL  = 8'd1;
  localparam logic [7:0] LOG        = 8'd2;
  localparam logic [7:0] FROG       = 8'd3;
  localparam logic [7:0] ENDBANK    = 8'd4;

  localparam logic [7:0] TRANSPARENT_RGB = 8'hFF;

  typedef enum logic [1:0] {
    WAIT_FRAME,
    ACCUM,
    REPORT
  } sel_state_t;

  // Fixed draw priority: frog over log over end bank over waterfall.
  function automatic logic [7:0] encode_object(input logic frog_req,
                                               input logic log_req,
                                               input logic endbank_req,
                                               input logic waterfall_req);
    if (frog_req)
      return FROG;
    else if (log_req)
      return LOG;
    else if (endbank_req)
      return ENDBANK;
    else if (waterfall_req)
      return WATERFALL;
    else
      return BACKGROUND;
  endfunction

endpackage

// File: rtl/object_select_encoder_overlap_counter.sv
// Saturating per-frame overlap counter with clear and load-from-inc restart.
module overlap_counter #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             clear,
  input  logic             load,
  input  logic             inc,
  output logic [CNT_W-1:0] total
);

  logic [CNT_W-1:0] count;

  // total is the value the counter takes at the next edge, so a frame that
  // closes this cycle can be judged including this cycle's increment.
  always_comb begin
    total = count;
    if (clear)
      total = '0;
    else if (load)
      total = CNT_W'(inc);
    else if (inc && (count != {CNT_W{1'b1}}))
      total = count + CNT_W'(1);
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn)
      count <= '0;
    else
      count <= total;
  end

endmodule

// File: rtl/object_select_encoder.sv
// Per-pixel object priority encoder with per-frame frog collision reporting.
// Optional macro OBJECT_TRANSPARENCY_EN: 8'hFF frog/log pixels are treated as no request.
module object_select_encoder
  import obj_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MIN_OVERLAP = 4
) (
  input  logic       CLK,
  input  logic       RESETn,
  input  logic       startOfFrame,
  input  logic       frog_draw_req,
  input  logic       log_draw_req,
  input  logic       waterfall_draw_req,
  input  logic       endbank_draw_req,
  input  logic [7:0] frog_RGB,
  input  logic [7:0] log_RGB,
  output logic [7:0] object_to_draw,
  output logic       frog_in_water,
  output logic       frog_on_log,
  output logic       frog_at_endbank,
  output logic       report_valid
);

  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_OVERLAP);

  logic frog_req;
  logic log_req;

`ifdef OBJECT_TRANSPARENCY_EN
  assign frog_req = frog_draw_req & (frog_RGB != TRANSPARENT_RGB);
  assign log_req  = log_draw_req  & (log_RGB  != TRANSPARENT_RGB);
`else
  logic unused_rgb;
  assign unused_rgb = ^{frog_RGB, log_RGB};
  assign frog_req   = frog_draw_req;
  assign log_req    = log_draw_req;
`endif

  logic water_term;
  logic on_log_term;
  logic bank_term;

  assign water_term  = frog_req & waterfall_draw_req & ~log_req;
  assign on_log_term = frog_req & log_req;
  assign bank_term   = frog_req & endbank_draw_req;

  // Overlap terms are delayed one cycle so a startOfFrame-cycle pixel lands in the new frame.
  logic water_d;
  logic on_log_d;
  logic bank_d;

  sel_state_t state;

  logic             cnt_clear;
  logic             cnt_load;
  logic [CNT_W-1:0] water_total;
  logic [CNT_W-1:0] log_total;
  logic [CNT_W-1:0] bank_total;

  assign cnt_clear = (state == WAIT_FRAME);
  assign cnt_load  = (state == REPORT);

  overlap_counter #(.CNT_W(CNT_W)) u_water_cnt (
    .CLK   (CLK),
    .RESETn(RESETn),
    .clear (cnt_clear),
    .load  (cnt_load),
    .inc   (water_d),
    .total (water_total)
  );

  overlap_counter #(.CNT_W(CNT_W)) u_log_cnt (
    .CLK   (CLK),
    .RESETn(RESETn),
    .clear (cnt_clear),
    .load  (cnt_load),
    .inc   (on_log_d),
    .total (log_total)
  );

  overlap_counter #(.CNT_W(CNT_W)) u_bank_cnt (
    .CLK   (CLK),
    .RESETn(RESETn),
    .clear (cnt_clear),
    .load  (cnt_load),
    .inc   (bank_d),
    .total (bank_total)
  );

  // A pulse seen in REPORT re-enters REPORT so back-to-back frames are each reported.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state           <= WAIT_FRAME;
      object_to_draw  <= BACKGROUND;
      water_d         <= 1'b0;
      on_log_d        <= 1'b0;
      bank_d          <= 1'b0;
      frog_in_water   <= 1'b0;
      frog_on_log     <= 1'b0;
      frog_at_endbank <= 1'b0;
      report_valid    <= 1'b0;
    end else begin
      object_to_draw <= encode_object(frog_req, log_req, endbank_draw_req, waterfall_draw_req);
      water_d        <= water_term;
      on_log_d       <= on_log_term;
      bank_d         <= bank_term;
      report_valid   <= 1'b0;
      case (state)
        WAIT_FRAME: begin
          if (startOfFrame)
            state <= ACCUM;
        end
        ACCUM, REPORT: begin
          if (startOfFrame) begin
            state           <= REPORT;
            report_valid    <= 1'b1;
            frog_in_water   <= (water_total >= MIN_CNT);
            frog_on_log     <= (log_total   >= MIN_CNT);
            frog_at_endbank <= (bank_total  >= MIN_CNT);
          end else begin
            state <= ACCUM;
          end
        end
        default: state <= WAIT_FRAME;
      endcase
    end
  end

endmodule

// File: doc/object_select_encoder.md
Name: object_select_encoder

Overview:
- Producer side of the object-code interface consumed by the VGA objects multiplexer.
- Per pixel, it resolves per-object draw requests into one registered 8-bit object_to_draw code using fixed priority.
- Per frame, it counts frog overlap pixels and reports frame-level collision flags (water, log, end bank) to game logic.
- Sits between the object drawers, the VGA objects multiplexer and the game-control FSM.

Parameters:
- CNT_W, 16, width of each per-frame overlap pixel counter; counters saturate at 2^CNT_W-1.
- MIN_OVERLAP, 4, minimum overlap pixels per frame for a collision flag to assert. Legal range 1..2^CNT_W-1.

Ports:
- CLK  in  1  pixel clock
- RESETn  in  1  asynchronous, active-low reset
- startOfFrame  in  1  one-cycle pulse marking the first pixel cycle of a frame
- frog_draw_req  in  1  frog drawer covers the current pixel
- log_draw_req  in  1  log drawer covers the current pixel
- waterfall_draw_req  in  1  waterfall drawer covers the current pixel
- endbank_draw_req  in  1  end-bank drawer covers the current pixel
- frog_RGB  in  8  frog RGB332 pixel; used only with the optional feature
- log_RGB  in  8  log RGB332 pixel; used only with the optional feature
- object_to_draw  out  8  registered object code
- frog_in_water  out  1  previous frame: frog overlapped waterfall, not log, at least MIN_OVERLAP pixels
- frog_on_log  out  1  previous frame: frog overlapped log at least MIN_OVERLAP pixels
- frog_at_endbank  out  1  previous frame: frog overlapped end bank at least MIN_OVERLAP pixels
- report_valid  out  1  one-cycle pulse when the collision flags update

Behaviour:
- Object codes: BACKGROUND=0, WATERFALL=1, LOG=2, FROG=3, ENDBANK=4.
- Priority, highest first: FROG > LOG > ENDBANK > WATERFALL > BACKGROUND.
- object_to_draw is registered, with 1-cycle latency from the request inputs.
- Reset values: every output 0; object_to_draw = BACKGROUND; all counters 0; FSM = WAIT_FRAME.
- Overlap terms, evaluated each cycle on the effective requests:
  - water = frog & waterfall & !log
  - on_log = frog & log
  - bank = frog & endbank
- Each overlap term increments its own CNT_W counter. Counters saturate; they never wrap.
- FSM states:
  - WAIT_FRAME: after reset, drop the partial frame. The encoder still runs. Counters are held at 0 and no report is issued. On startOfFrame, go to ACCUM.
  - ACCUM: counters accumulate. On startOfFrame, go to REPORT.
  - REPORT: lasts one cycle.
    - Each flag is set to (counter >= MIN_OVERLAP), using the counter values frozen in the startOfFrame cycle.
    - report_valid = 1.
    - Counters restart from that cycle's own overlap terms, so REPORT-cycle pixels count in the new frame. Then return to ACCUM.
- Request on the same cycle as startOfFrame: belongs to the new frame.
  - Its overlap is not counted in the closing frame.
  - It seeds the new counter in the REPORT cycle, using the delayed request.
- Back-to-back startOfFrame (1-cycle frame): REPORT handles it, then ACCUM sees the next pulse; no pulse is lost.
- Flags hold their value between reports; they change only in REPORT.
- Asynchronous reset mid-frame: all state returns to reset values, the FSM goes to WAIT_FRAME and no report is issued for the interrupted frame.
- Comparison with MIN_OVERLAP is unsigned at CNT_W width.

Optional Feature:
- Macro: OBJECT_TRANSPARENCY_EN
- Defined:
  - Effective frog_req = frog_draw_req & (frog_RGB != 8'hFF).
  - Effective log_req = log_draw_req & (log_RGB != 8'hFF).
  - Transparent pixels fall through to lower priority and do not count as overlap.
- Undefined: effective requests equal the raw requests; frog_RGB and log_RGB are ignored.

Decomposition:
- Package obj_pkg holds:
  - object-code localparams BACKGROUND..ENDBANK, 8 bits;
  - TRANSPARENT_RGB = 8'hFF;
  - typedef enum sel_state_t {WAIT_FRAME, ACCUM, REPORT}.
- One natural sub-module: overlap_counter.
  - Saturating CNT_W counter with clear-and-load and an inc input.
  - Instantiated three times.

Test Plan:
- frog=1, log=1, waterfall=1 at cycle N -> object_to_draw=3 at N+1; all requests 0 -> 0 at the next cycle.
- log=1, endbank=1 -> 2; endbank=1, waterfall=1 -> 4; waterfall only -> 1.
- Reset, pulse startOfFrame, 4 cycles frog & waterfall, pulse startOfFrame -> next cycle frog_in_water=1, report_valid=1 for exactly 1 cycle, other flags 0.
- MIN_OVERLAP=4, 3 cycles frog & log in a frame -> frog_on_log=0 at report; the next frame with 5 cycles -> 1.
- frog & endbank asserted on the startOfFrame cycle only -> counted in the new frame; the report for the closing frame shows frog_at_endbank=0.
- Assert RESETn low mid-ACCUM, release, send one startOfFrame -> no report_valid; a report appears only at the second startOfFrame.
- CNT_W=4, 40 overlap cycles -> counter saturates at 15; flag=1 with no wrap.
- OBJECT_TRANSPARENCY_EN defined, frog_RGB=8'hFF, log_draw_req=1 -> object_to_draw=2 and no on_log count.
